alarm_controller: RTL and testbench

//  Sequencing FSM around the 3-sensor motion alarm datapath (m2,m1,m0).

---
 rtl/alarm_controller_pkg.sv | 21 ++
 rtl/alarm_debounce.sv | 36 +++
 rtl/alarm_controller.sv | 128 ++++++++++++
 tb/tb_alarm_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the motion alarm controller: state codes, state width
// and a small sizing helper.
package alarm_controller_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_DISARMED    = 3'd0,
    S_EXIT_DELAY  = 3'd1,
    S_ARMED       = 3'd2,
    S_ENTRY_DELAY = 3'd3,
    S_ALARM       = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alarm_debounce.sv
// Debounce for the majority trigger: trig_db rises once trig has been high for
// DEBOUNCE consecutive edges and drops as soon as trig goes low.
module alarm_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  output logic trig_db
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] nxt_cnt;

  // Counter saturates at DEBOUNCE so a long-held trigger never wraps.
  always_comb begin
    nxt_cnt = '0;
    if (trig) begin
      nxt_cnt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      trig_db <= 1'b0;
    end else begin
      cnt_q   <= nxt_cnt;
      trig_db <= (nxt_cnt == CNT_MAX);
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Arming / exit delay / entry delay / siren sequencer for a 3-sensor motion alarm.
// Optional build macro SILENT_TIMEOUT_EN: siren auto-silences after ALARM_CYCLES and re-arms.
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int EXIT_CYCLES  = 16,
  parameter int ENTRY_CYCLES = 16,
  parameter int DEBOUNCE     = 4,
  parameter int ALARM_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m2,
  input  logic               m1,
  input  logic               m0,
  input  logic               arm,
  input  logic               disarm,
  output logic               A,
  output logic               armed,
  output logic               pending,
  output logic [STATE_W-1:0] state
);

  localparam int TIMER_W = $clog2(max3(EXIT_CYCLES, ENTRY_CYCLES, ALARM_CYCLES) + 1);
  localparam logic [TIMER_W-1:0] EXIT_LOAD  = TIMER_W'(EXIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ENTRY_LOAD = TIMER_W'(ENTRY_CYCLES - 1);

  logic               trig;
  logic               trig_db;
  logic               rearm_hold;
  state_t             state_q;
  state_t             nxt_state;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] nxt_timer;

  assign trig  = (m2 & m1) | (m2 & m0) | (m1 & m0);
  assign state = state_q;

  alarm_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .trig    (trig),
    .trig_db (trig_db)
  );

`ifdef SILENT_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] ALARM_LOAD = TIMER_W'(ALARM_CYCLES - 1);

  // After an auto-silence the still-high trig_db must drop before it can re-trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      rearm_hold <= 1'b0;
    end else if (state_q == S_ALARM && nxt_state == S_ARMED) begin
      rearm_hold <= 1'b1;
    end else if (!trig_db) begin
      rearm_hold <= 1'b0;
    end
  end
`else
  assign rearm_hold = 1'b0;
`endif

  always_comb begin
    nxt_state = state_q;
    nxt_timer = timer_q;
    case (state_q)
      S_DISARMED: begin
        if (arm) begin
          nxt_state = S_EXIT_DELAY;
          nxt_timer = EXIT_LOAD;
        end
      end
      S_EXIT_DELAY: begin
        if (timer_q == '0) nxt_state = S_ARMED;
        else               nxt_timer = timer_q - 1'b1;
      end
      S_ARMED: begin
        if (trig_db && !rearm_hold) begin
          nxt_state = S_ENTRY_DELAY;
          nxt_timer = ENTRY_LOAD;
        end
      end
      S_ENTRY_DELAY: begin
        if (timer_q == '0) begin
          nxt_state = S_ALARM;
`ifdef SILENT_TIMEOUT_EN
          nxt_timer = ALARM_LOAD;
`endif
        end else begin
          nxt_timer = timer_q - 1'b1;
        end
      end
      S_ALARM: begin
`ifdef SILENT_TIMEOUT_EN
        if (timer_q == '0) nxt_state = S_ARMED;
        else               nxt_timer = timer_q - 1'b1;
`endif
      end
      default: begin
        nxt_state = S_DISARMED;
        nxt_timer = '0;
      end
    endcase
    // Disarm beats every other event, including a simultaneous arm.
    if (disarm) begin
      nxt_state = S_DISARMED;
      nxt_timer = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_DISARMED;
      timer_q <= '0;
      A       <= 1'b0;
      armed   <= 1'b0;
      pending <= 1'b0;
    end else begin
      state_q <= nxt_state;
      timer_q <= nxt_timer;
      A       <= (nxt_state == S_ALARM);
      armed   <= (nxt_state == S_ARMED) || (nxt_state == S_ENTRY_DELAY) ||
                 (nxt_state == S_ALARM);
      pending <= (nxt_state == S_EXIT_DELAY) || (nxt_state == S_ENTRY_DELAY);
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: per-cycle expected {A,armed,pending,state}
// words are queued at drive time and popped against the DUT after each edge.
module tb_alarm_controller;

  localparam int W = 6;

  // Expected output words: {A, armed, pending, state[2:0]}
  localparam logic [W-1:0] E_DIS   = 6'b000_000;
  localparam logic [W-1:0] E_EXIT  = 6'b001_001;
  localparam logic [W-1:0] E_ARMED = 6'b010_010;
  localparam logic [W-1:0] E_ENTRY = 6'b011_011;
  localparam logic [W-1:0] E_ALARM = 6'b110_100;

  logic       clk = 1'b0;
  logic       reset;
  logic       m2, m1, m0;
  logic       arm, disarm;
  logic       A, armed, pending;
  logic [2:0] state;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alarm_controller #(
    .EXIT_CYCLES  (4),
    .ENTRY_CYCLES (3),
    .DEBOUNCE     (2),
    .ALARM_CYCLES (5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m2      (m2),
    .m1      (m1),
    .m0      (m0),
    .arm     (arm),
    .disarm  (disarm),
    .A       (A),
    .armed   (armed),
    .pending (pending),
    .state   (state)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got {A,armed,pending,state}=%b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic a, input logic d, input logic [2:0] m,
                             input logic [W-1:0] e, input string tag);
    arm    = a;
    disarm = d;
    {m2, m1, m0} = m;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check(tag_q.pop_front(), {A, armed, pending, state}, exp_q.pop_front());
  endtask

  task automatic drive_reset(input string tag);
    reset = 1'b1;
    drive_cycle(1'b0, 1'b0, 3'b000, E_DIS, tag);
    reset = 1'b0;
  endtask

  task automatic arm_to_armed(input logic [2:0] m, input string tag);
    drive_cycle(1'b1, 1'b0, m, E_EXIT, tag);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, m, E_EXIT, tag);
    drive_cycle(1'b0, 1'b0, m, E_ARMED, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] one;
    int         r;
    one = 3'b001;
    reset = 1'b1; arm = 1'b0; disarm = 1'b0; {m2, m1, m0} = 3'b000;

    drive_reset("reset0");
    drive_reset("reset1");

    // Triggers are ignored while disarmed
    drive_cycle(1'b0, 1'b0, 3'b111, E_DIS, "dis_trig_ignored");
    drive_cycle(1'b0, 1'b0, 3'b111, E_DIS, "dis_trig_ignored");
    drive_cycle(1'b0, 1'b0, 3'b000, E_DIS, "dis_idle");

    // 1. Exit delay: 4 pending cycles, arm mid-delay does not restart it
    drive_cycle(1'b1, 1'b0, 3'b000, E_EXIT,  "t1_arm");
    drive_cycle(1'b0, 1'b0, 3'b000, E_EXIT,  "t1_exit");
    drive_cycle(1'b1, 1'b0, 3'b000, E_EXIT,  "t1_arm_in_exit");
    drive_cycle(1'b0, 1'b0, 3'b000, E_EXIT,  "t1_exit_last");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ARMED, "t1_armed");

    // 2. Debounced intrusion, entry delay survives sensor clearing, disarm
    drive_cycle(1'b0, 1'b0, 3'b110, E_ARMED, "t2_db1");
    drive_cycle(1'b0, 1'b0, 3'b110, E_ARMED, "t2_db2");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ENTRY, "t2_entry");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ENTRY, "t2_entry2");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ENTRY, "t2_entry3");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ALARM, "t2_siren");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ALARM, "t2_siren_hold");
    drive_cycle(1'b0, 1'b1, 3'b000, E_DIS,   "t2_disarm");

    // 3. Single sensors never trigger; 1-cycle majority glitch is filtered
    arm_to_armed(3'b000, "t3_rearm");
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 3'b001, E_ARMED, "t3_m0_only");
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, 2);
      drive_cycle(1'b0, 1'b0, one << r, E_ARMED, "t3_single_rand");
    end
    drive_cycle(1'b0, 1'b0, 3'b011, E_ARMED, "t3_glitch");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ARMED, "t3_after_glitch");
    drive_cycle(1'b1, 1'b0, 3'b000, E_ARMED, "t3_arm_ignored");

    // 5a. arm+disarm together in exit delay
    drive_cycle(1'b0, 1'b1, 3'b000, E_DIS,  "t5_disarm");
    drive_cycle(1'b1, 1'b0, 3'b000, E_EXIT, "t5_arm");
    drive_cycle(1'b1, 1'b1, 3'b000, E_DIS,  "t5_arm_and_disarm");

    // 4. Sensors high through the exit delay: entry on the edge after ARMED
    arm_to_armed(3'b111, "t4_exit_trig");
    drive_cycle(1'b0, 1'b0, 3'b111, E_ENTRY, "t4_entry_next");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ENTRY, "t4_entry2");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ENTRY, "t4_entry3");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ALARM, "t4_siren");

    // 6. Siren timeout behaviour
`ifdef SILENT_TIMEOUT_EN
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 3'b000, E_ALARM, "t6_siren_on");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ARMED, "t6_auto_silence");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ARMED, "t6_rearmed");
    drive_cycle(1'b0, 1'b0, 3'b101, E_ARMED, "t6_fresh_db1");
    drive_cycle(1'b0, 1'b0, 3'b101, E_ARMED, "t6_fresh_db2");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ENTRY, "t6_reentry");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ENTRY, "t6_reentry2");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ENTRY, "t6_reentry3");
    drive_cycle(1'b0, 1'b0, 3'b000, E_ALARM, "t6_siren_again");
`else
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b0, 3'b000, E_ALARM, "t6_siren_latched");
`endif

    // 5b. Reset in ALARM clears everything on that edge
    drive_reset("t5_reset_in_alarm");
    drive_cycle(1'b0, 1'b0, 3'b000, E_DIS, "t5_after_reset");

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
